// File: rtl/fbuf_pkg.sv
// Shared framebuffer definitions: display timing, address sizing and the
// state encoding of the stream writer.
package fbuf_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int QVGA_H_ACTIVE = 320;
  localparam int QVGA_V_ACTIVE = 240;

  localparam int FBUF_PIXEL_WIDTH = 24;
  localparam int FBUF_CNT_WIDTH   = 13;

  localparam logic [1:0] ST_HOLD     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  // Smallest address width covering a width x height frame.
  function automatic int fbuf_addr_bits(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/fbuf_stream_writer_if.sv
// AXI4-Stream video input (RGB888, tuser = start of frame, tlast = end of line).
interface fbuf_stream_writer_if;
  import fbuf_pkg::*;

  logic [FBUF_PIXEL_WIDTH-1:0] s_axis_tdata;
  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic                        s_axis_tuser;
  logic                        s_axis_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    output s_axis_tready
  );

endinterface

// File: rtl/fbuf_pixel_pack.sv
// Registered RGB888 -> framebuffer word conversion: each channel keeps its MSBs.
module fbuf_pixel_pack
  import fbuf_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [FBUF_PIXEL_WIDTH-1:0] rgb,
  output logic [DATA_WIDTH-1:0]       word
);

  localparam int CW = DATA_WIDTH / 3;

  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] word_q;

  always_comb begin
    word_d = word_q;
    if (en) begin
      word_d = {rgb[23 -: CW], rgb[15 -: CW], rgb[7 -: CW]};
    end else begin
      word_d = word_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= {DATA_WIDTH{1'b0}};
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/fbuf_stream_writer.sv
// Writes an AXI4-Stream video feed into the framebuffer write port, line by
// line at y*FBUF_WIDTH + x, optionally starting frames only after vblank.
module fbuf_stream_writer
  import fbuf_pkg::*;
#(
  parameter int FBUF_WIDTH      = 640,
  parameter int FBUF_HEIGHT     = 480,
  parameter int FBUF_ADDR_WIDTH = fbuf_addr_bits(FBUF_WIDTH, FBUF_HEIGHT),
  parameter int FBUF_DATA_WIDTH = 12,
  parameter int SYNC_TO_EOF     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fbuf_stream_writer_if.slave        axis,
  input  logic                       eof_in,
  output logic                       fbuf_we,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_waddr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_wdata,
  output logic                       frame_done,
  output logic                       err_sof_early,
  output logic                       err_eol_early,
  output logic                       err_eol_late,
  input  logic                       err_clear
);

  localparam logic [FBUF_CNT_WIDTH-1:0]  X_LAST    = FBUF_CNT_WIDTH'(FBUF_WIDTH - 1);
  localparam logic [FBUF_CNT_WIDTH-1:0]  Y_LAST    = FBUF_CNT_WIDTH'(FBUF_HEIGHT - 1);
  localparam logic [FBUF_ADDR_WIDTH-1:0] LINE_STEP = FBUF_ADDR_WIDTH'(FBUF_WIDTH);
  localparam logic [1:0]                 ST_IDLE   = (SYNC_TO_EOF != 0) ? ST_HOLD : ST_WAIT_SOF;

  logic [1:0]                 state_d, state_q;
  logic [FBUF_CNT_WIDTH-1:0]  x_d, x_q;
  logic [FBUF_CNT_WIDTH-1:0]  y_d, y_q;
  logic [FBUF_ADDR_WIDTH-1:0] line_base_d, line_base_q;
  logic                       eof_prev_d, eof_prev_q;
  logic                       tready_d, tready_q;
  logic                       we_d, we_q;
  logic [FBUF_ADDR_WIDTH-1:0] waddr_d, waddr_q;
  logic                       done_d, done_q;
  logic                       err_sof_d, err_sof_q;
  logic                       err_early_d, err_early_q;
  logic                       err_late_d, err_late_q;

  logic                       accept_s;
  logic                       eol_s;
  logic                       set_sof_s, set_early_s, set_late_s;
  logic [1:0]                 eff_state_s;
  logic [FBUF_CNT_WIDTH-1:0]  cur_x_s, cur_y_s;
  logic [FBUF_ADDR_WIDTH-1:0] cur_base_s;

  assign accept_s = axis.s_axis_tvalid & tready_q;

  // Next-state, counter and write-port logic for one accepted beat.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    line_base_d = line_base_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    done_d      = 1'b0;
    set_sof_s   = 1'b0;
    set_early_s = 1'b0;
    set_late_s  = 1'b0;
    eol_s       = 1'b0;
    eff_state_s = state_q;
    cur_x_s     = x_q;
    cur_y_s     = y_q;
    cur_base_s  = line_base_q;

    case (state_q)
      ST_HOLD: begin
        if (eof_in && !eof_prev_q) begin
          state_d = ST_WAIT_SOF;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_WAIT_SOF, ST_ACTIVE, ST_DRAIN: begin
        if (accept_s) begin
          // A tuser beat restarts the frame from any accepting state.
          if (axis.s_axis_tuser) begin
            eff_state_s = ST_ACTIVE;
            cur_x_s     = {FBUF_CNT_WIDTH{1'b0}};
            cur_y_s     = {FBUF_CNT_WIDTH{1'b0}};
            cur_base_s  = {FBUF_ADDR_WIDTH{1'b0}};
            set_sof_s   = (state_q != ST_WAIT_SOF);
          end else begin
            eff_state_s = state_q;
          end

          if (eff_state_s == ST_ACTIVE) begin
            we_d    = 1'b1;
            waddr_d = cur_base_s + FBUF_ADDR_WIDTH'(cur_x_s);
            if (axis.s_axis_tlast) begin
              eol_s       = 1'b1;
              set_early_s = (cur_x_s != X_LAST);
            end else if (cur_x_s == X_LAST) begin
              set_late_s  = 1'b1;
              state_d     = ST_DRAIN;
              x_d         = cur_x_s;
              y_d         = cur_y_s;
              line_base_d = cur_base_s;
            end else begin
              state_d     = ST_ACTIVE;
              x_d         = cur_x_s + 13'd1;
              y_d         = cur_y_s;
              line_base_d = cur_base_s;
            end
          end else if (eff_state_s == ST_DRAIN) begin
            if (axis.s_axis_tlast) begin
              eol_s = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            state_d = ST_WAIT_SOF;
          end

          if (eol_s) begin
            if (cur_y_s == Y_LAST) begin
              done_d      = 1'b1;
              state_d     = ST_IDLE;
              x_d         = {FBUF_CNT_WIDTH{1'b0}};
              y_d         = {FBUF_CNT_WIDTH{1'b0}};
              line_base_d = {FBUF_ADDR_WIDTH{1'b0}};
            end else begin
              state_d     = ST_ACTIVE;
              x_d         = {FBUF_CNT_WIDTH{1'b0}};
              y_d         = cur_y_s + 13'd1;
              line_base_d = cur_base_s + LINE_STEP;
            end
          end else begin
            eol_s = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error flags, readiness and vblank edge history.
  always_comb begin
    err_sof_d   = (err_clear ? 1'b0 : err_sof_q)   | set_sof_s;
    err_early_d = (err_clear ? 1'b0 : err_early_q) | set_early_s;
    err_late_d  = (err_clear ? 1'b0 : err_late_q)  | set_late_s;
    tready_d    = (state_d != ST_HOLD);
    eof_prev_d  = eof_in;
  end

  // State registers; eof history resets high so a level present at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= {FBUF_CNT_WIDTH{1'b0}};
      y_q         <= {FBUF_CNT_WIDTH{1'b0}};
      line_base_q <= {FBUF_ADDR_WIDTH{1'b0}};
      eof_prev_q  <= 1'b1;
      tready_q    <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= {FBUF_ADDR_WIDTH{1'b0}};
      done_q      <= 1'b0;
      err_sof_q   <= 1'b0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_base_q <= line_base_d;
      eof_prev_q  <= eof_prev_d;
      tready_q    <= tready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      done_q      <= done_d;
      err_sof_q   <= err_sof_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
    end
  end

  fbuf_pixel_pack #(
    .DATA_WIDTH (FBUF_DATA_WIDTH)
  ) u_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (we_d),
    .rgb   (axis.s_axis_tdata),
    .word  (fbuf_wdata)
  );

  assign axis.s_axis_tready = tready_q;
  assign fbuf_we            = we_q;
  assign fbuf_waddr         = waddr_q;
  assign frame_done         = done_q;
  assign err_sof_early      = err_sof_q;
  assign err_eol_early      = err_early_q;
  assign err_eol_late       = err_late_q;

endmodule

// File: tb/tb_fbuf_stream_writer.sv
// Directed bench for fbuf_stream_writer on an 8x4 framebuffer with vblank sync.
module tb_fbuf_stream_writer;
  import fbuf_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 5;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          eof_in = 1'b0;
  logic          err_clear = 1'b0;
  logic          fbuf_we;
  logic [AW-1:0] fbuf_waddr;
  logic [DW-1:0] fbuf_wdata;
  logic          frame_done;
  logic          err_sof_early, err_eol_early, err_eol_late;

  fbuf_stream_writer_if axis_if ();

  fbuf_stream_writer #(
    .FBUF_WIDTH      (W),
    .FBUF_HEIGHT     (H),
    .FBUF_ADDR_WIDTH (AW),
    .FBUF_DATA_WIDTH (DW),
    .SYNC_TO_EOF     (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axis          (axis_if),
    .eof_in        (eof_in),
    .fbuf_we       (fbuf_we),
    .fbuf_waddr    (fbuf_waddr),
    .fbuf_wdata    (fbuf_wdata),
    .frame_done    (frame_done),
    .err_sof_early (err_sof_early),
    .err_eol_early (err_eol_early),
    .err_eol_late  (err_eol_late),
    .err_clear     (err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          tv, tu, tl, eof, clr;
    logic [23:0]   td;
    logic          ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    logic          edone, erdy;
    logic [2:0]    eerr;   // {sof_early, eol_early, eol_late}
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [DW-1:0] pk(input logic [23:0] d);
    return {d[23:20], d[15:12], d[7:4]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic tv, input logic tu, input logic tl, input logic eof,
                     input logic clr, input logic [23:0] td, input logic ewe,
                     input int eaddr, input logic edone, input logic erdy, input logic [2:0] eerr);
    vec_t v;
    v.tv = tv; v.tu = tu; v.tl = tl; v.eof = eof; v.clr = clr; v.td = td;
    v.ewe = ewe; v.eaddr = AW'(eaddr); v.edata = pk(td);
    v.edone = edone; v.erdy = erdy; v.eerr = eerr;
    vq.push_back(v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(fbuf_we), 32'd0);
    chk({tag, "_addr"}, 32'(fbuf_waddr), 32'd0);
    chk({tag, "_data"}, 32'(fbuf_wdata), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_rdy"}, 32'(axis_if.s_axis_tready), 32'd0);
    chk({tag, "_err"}, 32'({err_sof_early, err_eol_early, err_eol_late}), 32'd0);
  endtask

  initial begin
    logic [23:0] cd;
    logic [23:0] rd;
    int          nacc;
    logic        acc;

    axis_if.s_axis_tvalid = 1'b0;
    axis_if.s_axis_tuser  = 1'b0;
    axis_if.s_axis_tlast  = 1'b0;
    axis_if.s_axis_tdata  = 24'h000000;
    cd = 24'hF05A0F;

    // Vblank: a level high at reset release is ignored, a rising edge opens WAIT_SOF.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 0, 1'b0, 1'b0, 3'b000);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 1'b0, 1'b0, 3'b000);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 0, 1'b0, 1'b1, 3'b000);
    // Clean frame; eof_in toggling mid-frame must be ignored.
    for (int i = 0; i < 32; i++)
      add(1'b1, i == 0, (i % 8) == 7, 1'(i >> 2), 1'b0, 24'hAB12CD, 1'b1, i, i == 31, i != 31, 3'b000);
    for (int i = 0; i < 2; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 0, 1'b0, 1'b0, 3'b000);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 0, 1'b0, 1'b1, 3'b000);
    // Beats before tuser are dropped.
    for (int i = 0; i < 10; i++)
      add(1'b1, 1'b0, i == 3, 1'b0, 1'b0, 24'(i * 24'h111111), 1'b0, 0, 1'b0, 1'b1, 3'b000);
    for (int x = 0; x < 8; x++) add(1'b1, x == 0, x == 7, 1'b0, 1'b0, cd, 1'b1, x, 1'b0, 1'b1, 3'b000);
    // Early tlast at x=4 on line 1.
    for (int x = 0; x < 5; x++)
      add(1'b1, 1'b0, x == 4, 1'b0, 1'b0, cd, 1'b1, 8 + x, 1'b0, 1'b1, (x == 4) ? 3'b010 : 3'b000);
    for (int x = 0; x < 3; x++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cd, 1'b1, 16 + x, 1'b0, 1'b1, 3'b010);
    // Mid-frame tuser at line 2, x=3 restarts at address 0.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b1, 0, 1'b0, 1'b1, 3'b110);
    // Missing tlast at x=7, then drain until tlast.
    for (int x = 1; x < 8; x++)
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cd, 1'b1, x, 1'b0, 1'b1, (x == 7) ? 3'b111 : 3'b110);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, i == 3, 1'b0, 1'b0, cd, 1'b0, 0, 1'b0, 1'b1, 3'b111);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cd, 1'b1, 8, 1'b0, 1'b1, 3'b111);
    // Clear and a new early-EOL error in the same cycle: that flag stays set.
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, cd, 1'b1, 9, 1'b0, 1'b1, 3'b010);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cd, 1'b0, 0, 1'b0, 1'b1, 3'b000);
    for (int a = 16; a < 32; a++)
      add(1'b1, 1'b0, (a % 8) == 7, 1'b0, 1'b0, {8'(a * 37), 8'(a * 53 + 1), 8'(255 - a * 29)},
          1'b1, a, a == 31, a != 31, 3'b000);

    // Reset with eof_in already high.
    eof_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      axis_if.s_axis_tvalid = vq[i].tv;
      axis_if.s_axis_tuser  = vq[i].tu;
      axis_if.s_axis_tlast  = vq[i].tl;
      axis_if.s_axis_tdata  = vq[i].td;
      eof_in                = vq[i].eof;
      err_clear             = vq[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), 32'(fbuf_we), 32'(vq[i].ewe));
      if (vq[i].ewe) begin
        chk($sformatf("v%0d_addr", i), 32'(fbuf_waddr), 32'(vq[i].eaddr));
        chk($sformatf("v%0d_data", i), 32'(fbuf_wdata), 32'(vq[i].edata));
      end
      chk($sformatf("v%0d_done", i), 32'(frame_done), 32'(vq[i].edone));
      chk($sformatf("v%0d_rdy", i), 32'(axis_if.s_axis_tready), 32'(vq[i].erdy));
      chk($sformatf("v%0d_err", i), 32'({err_sof_early, err_eol_early, err_eol_late}), 32'(vq[i].eerr));
    end

    // Random tvalid gaps on a fresh frame, then reset mid-line.
    axis_if.s_axis_tvalid = 1'b0;
    err_clear = 1'b0;
    eof_in = 1'b1;
    @(posedge clk);
    #1;
    chk("gap_rdy", 32'(axis_if.s_axis_tready), 32'd1);
    eof_in = 1'b0;
    nacc = 0;
    for (int c = 0; c < 60 && nacc < 5; c++) begin
      rd = 24'($urandom);
      axis_if.s_axis_tvalid = 1'($urandom_range(0, 1));
      axis_if.s_axis_tuser  = (nacc == 0);
      axis_if.s_axis_tlast  = 1'b0;
      axis_if.s_axis_tdata  = rd;
      acc = axis_if.s_axis_tvalid;
      @(posedge clk);
      #1;
      chk("gap_we", 32'(fbuf_we), 32'(acc));
      if (acc) begin
        chk("gap_addr", 32'(fbuf_waddr), 32'(nacc));
        chk("gap_data", 32'(fbuf_wdata), 32'(pk(rd)));
        nacc++;
      end
    end
    chk("gap_beats", 32'(nacc), 32'd5);
    axis_if.s_axis_tvalid = 1'b1;
    axis_if.s_axis_tuser  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    axis_if.s_axis_tuser = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_rdy", 32'(axis_if.s_axis_tready), 32'd0);
      chk("post_rst_we", 32'(fbuf_we), 32'd0);
    end
    axis_if.s_axis_tvalid = 1'b0;
    eof_in = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_eof_rdy", 32'(axis_if.s_axis_tready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fbuf_stream_writer.md
Name: fbuf_stream_writer

Overview:
- Upstream stage of the framebuffer. Accepts an AXI4-Stream video feed (RGB888, tuser = start-of-frame, tlast = end-of-line).
- Converts each pixel to the framebuffer word format and writes it into the write port of the dual-port framebuffer BRAM.
- The scan-out timing generator reads the same BRAM on the other port and addresses it as y*FBUF_WIDTH + x.
- Frame starts can be held off until the display enters vertical blanking, which limits tearing.

Parameters:
- FBUF_WIDTH, 640, stored (already downscaled) frame width in pixels; 1..4095.
- FBUF_HEIGHT, 480, stored frame height in lines; 1..4095.
- FBUF_ADDR_WIDTH, 19, framebuffer address width; must satisfy 2^FBUF_ADDR_WIDTH >= FBUF_WIDTH*FBUF_HEIGHT.
- FBUF_DATA_WIDTH, 12, framebuffer word width; must be a multiple of 3 and at most 24. Each channel keeps the FBUF_DATA_WIDTH/3 MSBs.
- SYNC_TO_EOF, 1, when 1, a new frame may only begin after a rising edge of eof_in; when 0, frames are accepted back-to-back.

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  24  pixel, {R[23:16],G[15:8],B[7:0]}
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&tready
- s_axis_tuser  in  1  start of frame (first pixel)
- s_axis_tlast  in  1  last pixel of line
- eof_in  in  1  vertical-blanking flag from the scan-out timing generator (same clock)
- fbuf_we  out  1  BRAM write enable
- fbuf_waddr  out  FBUF_ADDR_WIDTH  BRAM write address
- fbuf_wdata  out  FBUF_DATA_WIDTH  BRAM write data
- frame_done  out  1  one-cycle pulse when a complete frame has been written
- err_sof_early  out  1  sticky: tuser seen mid-frame
- err_eol_early  out  1  sticky: tlast before x=FBUF_WIDTH-1
- err_eol_late  out  1  sticky: no tlast at x=FBUF_WIDTH-1
- err_clear  in  1  synchronous clear of the sticky error flags

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state=WAIT_SOF if SYNC_TO_EOF=0, else HOLD
  - x=y=0, line_base=0
  - all outputs 0, including s_axis_tready, fbuf_we and the error flags
- Counters: x and y are 13 bits. Address = line_base + x. line_base advances by FBUF_WIDTH at each line end. No multiplier.
- Write latency: an accepted beat produces fbuf_we=1 with its address and data on the next cycle (registered). fbuf_we=0 on every other cycle.
- State machine, per accepted beat:
  - HOLD:
    - tready=0.
    - eof_in rising edge (registered previous value) -> WAIT_SOF.
    - An eof_in already high on reset release does not count as an edge.
  - WAIT_SOF:
    - tready=1.
    - Beats without tuser are discarded (no write).
    - A beat with tuser is written at address 0, x becomes 1, and state -> ACTIVE.
  - ACTIVE:
    - tready=1.
    - tuser=1 mid-frame: set err_sof_early; restart the frame with this beat at address 0 (x=1, y=0).
    - Normal beat: write, x+1.
    - Beat at x=FBUF_WIDTH-1: write. If tlast=1: x=0, y+1, line_base+=FBUF_WIDTH. If tlast=0: set err_eol_late and go to DRAIN.
    - tlast at x<FBUF_WIDTH-1: write the beat, set err_eol_early, advance to the next line. The unwritten remainder keeps its old contents.
    - Completion of line FBUF_HEIGHT-1 (by either the normal or early-EOL path): pulse frame_done together with the final fbuf_we; state -> HOLD if SYNC_TO_EOF else WAIT_SOF; x=y=line_base=0.
  - DRAIN:
    - tready=1; discard beats.
    - tlast -> advance the line (with the frame-completion check above) -> ACTIVE.
    - tuser -> treated as in ACTIVE (restart).
- tuser and tlast on the same beat at x=FBUF_WIDTH-1 with FBUF_WIDTH=1: restart takes priority, then the end-of-line rules apply.
- Pixel conversion: each channel keeps its FBUF_DATA_WIDTH/3 MSBs; no rounding.
- Error flags:
  - Flags are sticky until err_clear.
  - If err_clear and a new error occur in the same cycle, the flag is set.
- eof_in is only used in HOLD; it is ignored in all other states.

Decomposition:
- Shared package fbuf_pkg:
  - timing localparams per resolution (width/height/porches), already used by the scan-out side
  - constant for address width calculation
  - FSM state encoding (HOLD, WAIT_SOF, ACTIVE, DRAIN)
- Sub-module: fbuf_pixel_pack (registered RGB888 -> FBUF_DATA_WIDTH truncation).
- Everything else stays in one module.

Test Plan (FBUF_WIDTH=8, FBUF_HEIGHT=4, FBUF_DATA_WIDTH=12, SYNC_TO_EOF=1):
- Reset, then eof_in pulse, then a clean 32-beat frame with tdata=0xAB12CD and tvalid held -> writes to addresses 0..31 with wdata=0xA1C; frame_done coincides with the addr=31 write; tready=0 until the next eof_in rise.
- 10 beats without tuser, then a valid frame -> no writes for the first 10 beats; the first write is addr 0.
- tlast at x=4 on line 1 -> err_eol_early=1; the next beat is written to addr 16.
- No tlast at x=7 on line 0, then 3 extra beats and a tlast -> err_eol_late=1, 4 beats discarded, next write addr 8.
- tuser at line 2, x=3 -> err_sof_early=1, that beat written to addr 0; err_clear then clears all flags.
- Random tvalid gaps plus an rst_n assert mid-line -> outputs 0 immediately; after release, HOLD until the next eof_in rise.
